// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding,
// port-index constants and a small port helper.
package mem_arb_pkg;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } arb_state_e;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   // Index of the port that is not p (two-port round-robin step).
   function automatic logic other_port(input logic p);
      return (p == PORT0) ? PORT1 : PORT0;
   endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin winner selection. Purely combinational: a lone
// requester wins; on a tie the port that did not own the last access wins.
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic req0,
   input  logic req1,
   input  logic last_owner,
   output logic winner
);

   // Pick the winning port index from the current requests.
   always_comb begin
      winner = PORT0;
      if (req0 && req1) begin
         winner = other_port(last_owner);
      end else if (req1) begin
         winner = PORT1;
      end else begin
         winner = PORT0;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single combinational-read memory.
// One access takes an ACCESS cycle followed by an IDLE cycle; the read data
// seen at the end of ACCESS (pre-write content for writes) is returned on
// the owner's rdata with a one-cycle rvalid pulse.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_write_en,
   input  logic [DATA_W-1:0] readData,
   output logic              busy
);

   arb_state_e        state_q, state_d;
   logic              owner_q, owner_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              last_owner_q, last_owner_d;
   logic              gnt0_q, gnt0_d;
   logic              gnt1_q, gnt1_d;
   logic              rvalid0_q, rvalid0_d;
   logic              rvalid1_q, rvalid1_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              winner_s;

   rr_pick2 u_pick (
      .req0       (req0),
      .req1       (req1),
      .last_owner (last_owner_q),
      .winner     (winner_s)
   );

   // Next-state logic: accept a request in IDLE, complete it in ACCESS.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      last_owner_d = last_owner_q;
      rdata0_d     = rdata0_q;
      rdata1_d     = rdata1_q;
      gnt0_d       = 1'b0;
      gnt1_d       = 1'b0;
      rvalid0_d    = 1'b0;
      rvalid1_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               state_d      = ACCESS;
               owner_d      = winner_s;
               last_owner_d = winner_s;
               we_d         = (winner_s == PORT1) ? we1    : we0;
               addr_d       = (winner_s == PORT1) ? addr1  : addr0;
               wdata_d      = (winner_s == PORT1) ? wdata1 : wdata0;
               gnt0_d       = (winner_s == PORT0);
               gnt1_d       = (winner_s == PORT1);
            end else begin
               state_d = IDLE;
            end
         end
         ACCESS: begin
            state_d = IDLE;
            if (owner_q == PORT1) begin
               rdata1_d  = readData;
               rvalid1_d = 1'b1;
            end else begin
               rdata0_d  = readData;
               rvalid0_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any access in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         owner_q      <= PORT0;
         we_q         <= 1'b0;
         addr_q       <= {ADDR_W{1'b0}};
         wdata_q      <= {DATA_W{1'b0}};
         last_owner_q <= PORT1;
         gnt0_q       <= 1'b0;
         gnt1_q       <= 1'b0;
         rvalid0_q    <= 1'b0;
         rvalid1_q    <= 1'b0;
         rdata0_q     <= {DATA_W{1'b0}};
         rdata1_q     <= {DATA_W{1'b0}};
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         last_owner_q <= last_owner_d;
         gnt0_q       <= gnt0_d;
         gnt1_q       <= gnt1_d;
         rvalid0_q    <= rvalid0_d;
         rvalid1_q    <= rvalid1_d;
         rdata0_q     <= rdata0_d;
         rdata1_q     <= rdata1_d;
      end
   end

   // Memory-side controls come straight from registered state so the write
   // enable falls the moment reset clears the FSM.
   assign address        = addr_q;
   assign mem_write_data = wdata_q;
   assign mem_write_en   = (state_q == ACCESS) && we_q;
   assign busy           = (state_q == ACCESS);

   assign gnt0    = gnt0_q;
   assign gnt1    = gnt1_q;
   assign rvalid0 = rvalid0_q;
   assign rvalid1 = rvalid1_q;
   assign rdata0  = rdata0_q;
   assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected completions,
// a negedge monitor pops and compares them when rvalid appears.
module tb_mem_arbiter;

   localparam int AW = 16;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0, we0, req1, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          gnt0, gnt1, rvalid0, rvalid1;
   logic [DW-1:0] rdata0, rdata1;
   logic [AW-1:0] address;
   logic [DW-1:0] mem_write_data;
   logic          mem_write_en;
   logic [DW-1:0] readData;
   logic          busy;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk            (clk),
      .rst            (rst),
      .req0           (req0),
      .we0            (we0),
      .addr0          (addr0),
      .wdata0         (wdata0),
      .req1           (req1),
      .we1            (we1),
      .addr1          (addr1),
      .wdata1         (wdata1),
      .gnt0           (gnt0),
      .gnt1           (gnt1),
      .rvalid0        (rvalid0),
      .rvalid1        (rvalid1),
      .rdata0         (rdata0),
      .rdata1         (rdata1),
      .address        (address),
      .mem_write_data (mem_write_data),
      .mem_write_en   (mem_write_en),
      .readData       (readData),
      .busy           (busy)
   );

   // Memory model: combinational read, write on rising edge.
   logic [DW-1:0] mem [0:65535];
   logic          mem_clr;

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 65536; i++) mem[i] <= '0;
      end else if (mem_write_en) begin
         mem[address] <= mem_write_data;
      end
   end

   assign readData = mem[address];

   typedef struct packed {
      logic          port;
      logic [DW-1:0] data;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Monitor: exclusivity of per-port pulses and in-order completion check.
   always @(negedge clk) begin
      exp_t e;
      if (gnt0 || gnt1 || rvalid0 || rvalid1)
         check("pulse_exclusive", 32'({gnt0 & gnt1, rvalid0 & rvalid1}), 32'd0);
      if (rvalid0 || rvalid1) begin
         if (sb_q.size() == 0) begin
            check("unexpected_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
         end else begin
            e = sb_q.pop_front();
            check("rvalid_port", 32'(rvalid1), 32'(e.port));
            check("rdata", 32'(e.port ? rdata1 : rdata0), 32'(e.data));
         end
      end
   end

   task automatic wait_drain();
      int k = 0;
      while (sb_q.size() != 0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (sb_q.size() != 0) begin
         check("drain_timeout", 32'(sb_q.size()), 32'd0);
         sb_q.delete();
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic do_access(input logic port, input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd);
      @(posedge clk);
      #1;
      if (port) begin
         req1 = 1'b1; we1 = wr; addr1 = a; wdata1 = wd;
      end else begin
         req0 = 1'b1; we0 = wr; addr0 = a; wdata0 = wd;
      end
      sb_q.push_back({port, exp_rd});
      @(posedge clk);
      @(negedge clk);
      check("gnt_access", 32'({gnt1, gnt0}), port ? 32'd2 : 32'd1);
      check("busy_access", 32'(busy), 32'd1);
      check("mem_we_access", 32'(mem_write_en), 32'(wr));
      check("address_access", 32'(address), 32'(a));
      if (wr) check("wdata_access", 32'(mem_write_data), 32'(wd));
      @(posedge clk);
      #1;
      req0 = 1'b0;
      req1 = 1'b0;
      @(negedge clk);
      check("mem_we_idle", 32'(mem_write_en), 32'd0);
      check("busy_idle", 32'(busy), 32'd0);
      check("address_hold", 32'(address), 32'(a));
      wait_drain();
   endtask

   initial begin
      rst = 1'b1; mem_clr = 1'b1;
      req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
      req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
      check("rst_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
      check("rst_mem_we_busy", 32'({mem_write_en, busy}), 32'd0);
      check("rst_address", 32'(address), 32'd0);
      check("rst_wdata", 32'(mem_write_data), 32'd0);
      check("rst_rdata", 32'({rdata1, rdata0}), 32'd0);
      @(negedge clk);
      mem_clr = 1'b0;
      rst = 1'b0;

      // Single write then read from the other port
      do_access(1'b0, 1'b1, 16'h0003, 16'hA5A5, 16'h0000);
      do_access(1'b1, 1'b0, 16'h0003, 16'h0000, 16'hA5A5);

      // Write returns pre-write contents
      do_access(1'b0, 1'b1, 16'h0005, 16'h1111, 16'h0000);
      do_access(1'b0, 1'b1, 16'h0005, 16'h2222, 16'h1111);
      do_access(1'b1, 1'b0, 16'h0005, 16'h0000, 16'h2222);
      check("rdata0_hold", 32'(rdata0), 32'h1111);

      // Tie after reset: port 0 first, then alternation
      apply_reset();
      @(posedge clk);
      #1;
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0003;
      req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0005;
      sb_q.push_back({1'b0, 16'hA5A5});
      sb_q.push_back({1'b1, 16'h2222});
      sb_q.push_back({1'b0, 16'hA5A5});
      sb_q.push_back({1'b1, 16'h2222});
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("tie_gnt0", 32'(gnt0), 32'((i % 4) == 0));
         check("tie_gnt1", 32'(gnt1), 32'((i % 4) == 2));
      end
      req0 = 1'b0;
      req1 = 1'b0;
      wait_drain();

      // Reset during the ACCESS cycle of a write
      @(posedge clk);
      #1;
      req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0007; wdata0 = 16'hFFFF;
      @(posedge clk);
      @(negedge clk);
      check("abort_gnt0", 32'(gnt0), 32'd1);
      check("abort_mem_we_before", 32'(mem_write_en), 32'd1);
      rst = 1'b1;
      #1;
      check("abort_mem_we_after", 32'(mem_write_en), 32'd0);
      check("abort_busy_after", 32'(busy), 32'd0);
      req0 = 1'b0; we0 = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort_no_rvalid", 32'({rvalid1, rvalid0}), 32'd0);
      end
      do_access(1'b1, 1'b0, 16'h0007, 16'h0000, 16'h0000);

      // Back-to-back single requester on port 1
      @(posedge clk);
      #1;
      req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0003;
      for (int i = 0; i < 3; i++) sb_q.push_back({1'b1, 16'hA5A5});
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("b2b_gnt1", 32'(gnt1), 32'((i % 2) == 1));
         check("b2b_rvalid1", 32'(rvalid1), 32'((i % 2) == 0));
         check("b2b_port0_quiet", 32'({gnt0, rvalid0}), 32'd0);
      end
      req1 = 1'b0;
      wait_drain();

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
